// File: rtl/psum_accumulator.sv
// Accumulates adder-tree sums over cfg_groups channel groups, then adds bias and applies round/shift, saturate and ReLU.
// Result registered one cycle after the completing input. When the output is full a completion is dropped and ovf_err is set.
`ifndef CNN_XLEN
`define CNN_XLEN 16
`endif

package psum_pkg;
  typedef enum logic {INVALID = 1'b0, VALID = 1'b1} pe_state_t;
endpackage

module psum_accumulator
  import psum_pkg::*;
#(
  parameter int DATA_WID = `CNN_XLEN,
  parameter int ACC_WID  = 2 * `CNN_XLEN,
  parameter int GRP_WID  = 8,
  parameter int SHF_WID  = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  pe_state_t                  status_in,
  input  logic signed [DATA_WID-1:0] data_in,
  input  logic                       flush,
  input  logic        [GRP_WID-1:0]  cfg_groups,
  input  logic        [SHF_WID-1:0]  cfg_shift,
  input  logic                       cfg_relu_en,
  input  logic signed [DATA_WID-1:0] bias,
  input  logic                       out_ready,
  output pe_state_t                  status_out,
  output logic signed [DATA_WID-1:0] data_out,
  output logic                       busy,
  output logic                       ovf_err
);

  typedef enum logic {S_IDLE = 1'b0, S_ACCUM = 1'b1} state_t;

  localparam logic signed [ACC_WID-1:0] SAT_MAX = {{(ACC_WID-DATA_WID+1){1'b0}}, {(DATA_WID-1){1'b1}}};
  localparam logic signed [ACC_WID-1:0] SAT_MIN = {{(ACC_WID-DATA_WID+1){1'b1}}, {(DATA_WID-1){1'b0}}};
  localparam logic        [ACC_WID-1:0] ONE     = {{(ACC_WID-1){1'b0}}, 1'b1};

  state_t                      r_state, w_state_nxt;
  logic signed [ACC_WID-1:0]   r_acc, w_acc_nxt;
  logic        [GRP_WID-1:0]   r_grp_cnt, w_grp_cnt_nxt;
  logic        [GRP_WID-1:0]   r_groups;
  logic        [SHF_WID-1:0]   r_shift;
  logic                        r_relu;
  logic signed [DATA_WID-1:0]  r_bias;
  logic                        r_out_vld;
  logic signed [DATA_WID-1:0]  r_out_dat;
  logic                        r_ovf;

  logic                        w_in_vld;
  logic                        w_complete;
  logic                        w_latch_cfg;
  logic                        w_pop;
  logic        [GRP_WID-1:0]   w_groups_live;
  logic        [SHF_WID-1:0]   w_shift_eff;
  logic                        w_relu_eff;
  logic signed [DATA_WID-1:0]  w_bias_eff;
  logic signed [ACC_WID-1:0]   w_din_ext;
  logic signed [ACC_WID-1:0]   w_bias_ext;
  logic signed [ACC_WID-1:0]   w_acc_base;
  logic signed [ACC_WID-1:0]   w_sum;
  logic        [ACC_WID-1:0]   w_rnd;
  logic signed [ACC_WID-1:0]   w_shifted;
  logic signed [DATA_WID-1:0]  w_result;

  assign w_in_vld      = (status_in == VALID) && !flush;
  assign w_pop         = r_out_vld && out_ready;
  assign w_groups_live = (cfg_groups == '0) ? {{(GRP_WID-1){1'b0}}, 1'b1} : cfg_groups;

  // In IDLE the completing input is also the latching input, so use live config.
  assign w_shift_eff = (r_state == S_IDLE) ? cfg_shift   : r_shift;
  assign w_relu_eff  = (r_state == S_IDLE) ? cfg_relu_en : r_relu;
  assign w_bias_eff  = (r_state == S_IDLE) ? bias        : r_bias;

  assign w_din_ext  = {{(ACC_WID-DATA_WID){data_in[DATA_WID-1]}}, data_in};
  assign w_bias_ext = {{(ACC_WID-DATA_WID){w_bias_eff[DATA_WID-1]}}, w_bias_eff};
  assign w_acc_base = (r_state == S_ACCUM) ? r_acc : '0;
  assign w_sum      = w_acc_base + w_din_ext + w_bias_ext;
  assign w_rnd      = (w_shift_eff != '0) ? (ONE << (w_shift_eff - SHF_WID'(1))) : '0;
  assign w_shifted  = (w_sum + $signed(w_rnd)) >>> w_shift_eff;

  always_comb begin
    w_result = w_shifted[DATA_WID-1:0];
    if (w_shifted > SAT_MAX) begin
      w_result = SAT_MAX[DATA_WID-1:0];
    end else if (w_shifted < SAT_MIN) begin
      w_result = SAT_MIN[DATA_WID-1:0];
    end
    if (w_relu_eff && w_result[DATA_WID-1]) begin
      w_result = '0;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_acc_nxt     = r_acc;
    w_grp_cnt_nxt = r_grp_cnt;
    w_complete    = 1'b0;
    w_latch_cfg   = 1'b0;
    if (flush) begin
      w_state_nxt   = S_IDLE;
      w_acc_nxt     = '0;
      w_grp_cnt_nxt = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_in_vld) begin
            w_latch_cfg = 1'b1;
            if (w_groups_live == GRP_WID'(1)) begin
              w_complete = 1'b1;
            end else begin
              w_acc_nxt     = w_din_ext;
              w_grp_cnt_nxt = GRP_WID'(1);
              w_state_nxt   = S_ACCUM;
            end
          end
        end
        S_ACCUM: begin
          if (w_in_vld) begin
            if (r_grp_cnt == r_groups - GRP_WID'(1)) begin
              w_complete    = 1'b1;
              w_state_nxt   = S_IDLE;
              w_acc_nxt     = '0;
              w_grp_cnt_nxt = '0;
            end else begin
              w_acc_nxt     = r_acc + w_din_ext;
              w_grp_cnt_nxt = r_grp_cnt + GRP_WID'(1);
            end
          end
        end
        default: begin
          w_state_nxt   = S_IDLE;
          w_acc_nxt     = '0;
          w_grp_cnt_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_acc     <= '0;
      r_grp_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_acc     <= w_acc_nxt;
      r_grp_cnt <= w_grp_cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_groups <= '0;
      r_shift  <= '0;
      r_relu   <= 1'b0;
      r_bias   <= '0;
    end else if (w_latch_cfg) begin
      r_groups <= w_groups_live;
      r_shift  <= cfg_shift;
      r_relu   <= cfg_relu_en;
      r_bias   <= bias;
    end
  end

  // A completion may only load when the register is empty or being popped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_vld <= 1'b0;
      r_out_dat <= '0;
      r_ovf     <= 1'b0;
    end else if (w_complete) begin
      if (!r_out_vld || w_pop) begin
        r_out_vld <= 1'b1;
        r_out_dat <= w_result;
      end else begin
        r_ovf <= 1'b1;
      end
    end else if (w_pop) begin
      r_out_vld <= 1'b0;
    end
  end

  assign status_out = r_out_vld ? VALID : INVALID;
  assign data_out   = r_out_dat;
  assign busy       = (r_state == S_ACCUM);
  assign ovf_err    = r_ovf;

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed plus randomized bench for psum_accumulator against a pixel-level reference model.
module tb_psum_accumulator;
  import psum_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  pe_state_t   status_in = INVALID;
  logic [15:0] data_in = '0;
  logic        flush = 1'b0;
  logic [7:0]  cfg_groups = 8'd1;
  logic [4:0]  cfg_shift = '0;
  logic        cfg_relu_en = 1'b0;
  logic [15:0] bias = '0;
  logic        out_ready = 1'b1;
  pe_state_t   status_out;
  logic [15:0] data_out;
  logic        busy;
  logic        ovf_err;

  int n_cmp = 0;
  int n_err = 0;

  psum_accumulator dut (
    .clk        (clk),
    .reset      (reset),
    .status_in  (status_in),
    .data_in    (data_in),
    .flush      (flush),
    .cfg_groups (cfg_groups),
    .cfg_shift  (cfg_shift),
    .cfg_relu_en(cfg_relu_en),
    .bias       (bias),
    .out_ready  (out_ready),
    .status_out (status_out),
    .data_out   (data_out),
    .busy       (busy),
    .ovf_err    (ovf_err)
  );

  always #5 clk = ~clk;

  // Reference model: counts inputs of the current pixel and sums them exactly.
  bit          m_in_pixel;
  int          m_cnt;
  int          m_groups;
  int          m_shift;
  bit          m_relu;
  longint      m_sum;
  longint      m_bias;
  bit          m_vld;
  logic [15:0] m_dat;
  bit          m_ovf;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, act, act, exp, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_result(input longint s, input int sh, input bit relu);
    longint v;
    v = s;
    if (sh > 0) v = (v + (longint'(1) << (sh - 1))) >>> sh;
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
    if (relu && v < 0) v = 0;
    return v[15:0];
  endfunction

  task automatic m_reset();
    m_in_pixel = 0; m_cnt = 0; m_groups = 1; m_shift = 0; m_relu = 0;
    m_sum = 0; m_bias = 0; m_vld = 0; m_dat = '0; m_ovf = 0;
  endtask

  task automatic model_update();
    bit pop;
    bit done;
    logic [15:0] res;
    pop  = m_vld && out_ready;
    done = 0;
    if (!reset) begin
      m_reset();
      return;
    end
    if (flush) begin
      m_in_pixel = 0; m_cnt = 0; m_sum = 0;
    end else if (status_in == VALID) begin
      if (!m_in_pixel) begin
        m_groups = (cfg_groups == 0) ? 1 : int'(cfg_groups);
        m_shift  = int'(cfg_shift);
        m_relu   = cfg_relu_en;
        m_bias   = longint'($signed(bias));
        m_sum    = 0;
        m_cnt    = 0;
      end
      m_sum = m_sum + longint'($signed(data_in));
      m_cnt++;
      if (m_cnt == m_groups) begin
        done = 1; m_in_pixel = 0;
      end else begin
        m_in_pixel = 1;
      end
    end
    if (done) begin
      res = ref_result(m_sum + m_bias, m_shift, m_relu);
      m_sum = 0; m_cnt = 0;
      if (!m_vld || pop) begin
        m_vld = 1; m_dat = res;
      end else begin
        m_ovf = 1;
      end
    end else if (pop) begin
      m_vld = 0;
    end
  endtask

  task automatic check_all();
    chk("status", {31'd0, status_out == VALID}, {31'd0, m_vld});
    chk("data", {16'd0, data_out}, {16'd0, m_dat});
    chk("busy", {31'd0, busy}, {31'd0, m_in_pixel});
    chk("ovf", {31'd0, ovf_err}, {31'd0, m_ovf});
  endtask

  task automatic cycle();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_all();
  endtask

  task automatic feed(input bit v, input logic [15:0] d);
    status_in = v ? VALID : INVALID;
    data_in   = d;
    cycle();
  endtask

  task automatic cfg(input logic [7:0] g, input logic [4:0] sh, input logic relu, input logic [15:0] b);
    cfg_groups = g; cfg_shift = sh; cfg_relu_en = relu; bias = b;
  endtask

  initial begin
    int busy_cycles;
    m_reset();
    #1;
    chk("rst_status", {31'd0, status_out == VALID}, 32'd0);
    chk("rst_data", {16'd0, data_out}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ovf", {31'd0, ovf_err}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Four-group pixel, back-to-back inputs
    cfg(8'd4, 5'd0, 1'b0, 16'd0);
    out_ready = 1'b1;
    busy_cycles = 0;
    feed(1, 16'd10);  busy_cycles += int'(busy);
    feed(1, 16'd20);  busy_cycles += int'(busy);
    feed(1, -16'sd5); busy_cycles += int'(busy);
    feed(1, 16'd7);   busy_cycles += int'(busy);
    chk("t1_vld", {31'd0, status_out == VALID}, 32'd1);
    chk("t1_data", {16'd0, data_out}, 32'd32);
    feed(0, 16'd0);   busy_cycles += int'(busy);
    chk("t1_popped", {31'd0, status_out == VALID}, 32'd0);
    chk("t1_busy_cycles", busy_cycles, 32'd3);

    // Bubbles, bias and rounding shift
    cfg(8'd3, 5'd2, 1'b0, -16'sd50);
    feed(1, 16'd100);
    feed(0, 16'd999);
    feed(0, 16'd999);
    feed(1, 16'd200);
    chk("t2_busy", {31'd0, busy}, 32'd1);
    feed(1, 16'd300);
    chk("t2_data", {16'd0, data_out}, 32'd138);

    // Saturation and ReLU
    cfg(8'd2, 5'd0, 1'b0, 16'd0);
    feed(1, 16'd32767); feed(1, 16'd32767);
    chk("t3_satpos", {16'd0, data_out}, 32'h7FFF);
    feed(1, -16'sd20000); feed(1, -16'sd20000);
    chk("t3_satneg", {16'd0, data_out}, 32'h8000);
    cfg_relu_en = 1'b1;
    feed(1, -16'sd20000); feed(1, -16'sd20000);
    chk("t3_relu", {16'd0, data_out}, 32'd0);
    cfg_relu_en = 1'b0;
    feed(0, 16'd0);

    // Backpressure and overflow
    cfg(8'd1, 5'd0, 1'b0, 16'd0);
    out_ready = 1'b0;
    feed(1, 16'd5);
    chk("t4_held", {16'd0, data_out}, 32'd5);
    feed(1, 16'd9);
    chk("t4_drop_data", {16'd0, data_out}, 32'd5);
    chk("t4_drop_ovf", {31'd0, ovf_err}, 32'd1);
    out_ready = 1'b1;
    feed(0, 16'd0);
    chk("t4_pop", {31'd0, status_out == VALID}, 32'd0);
    chk("t4_ovf_sticky", {31'd0, ovf_err}, 32'd1);
    out_ready = 1'b0;
    feed(1, 16'd7);
    out_ready = 1'b1;
    feed(1, 16'd11);
    chk("t4_swap_data", {16'd0, data_out}, 32'd11);
    chk("t4_swap_vld", {31'd0, status_out == VALID}, 32'd1);

    // Flush discards the partial sum and the concurrent input
    cfg(8'd4, 5'd0, 1'b0, 16'd0);
    feed(1, 16'd3); feed(1, 16'd3);
    flush = 1'b1;
    feed(1, 16'd100);
    flush = 1'b0;
    chk("t5_flush_busy", {31'd0, busy}, 32'd0);
    feed(1, 16'd1); feed(1, 16'd1); feed(1, 16'd1); feed(1, 16'd1);
    chk("t5_data", {16'd0, data_out}, 32'd4);

    // Asynchronous reset mid-pixel with a full output register
    cfg(8'd1, 5'd0, 1'b0, 16'd0);
    out_ready = 1'b0;
    feed(1, 16'd77);
    cfg_groups = 8'd4;
    feed(1, 16'd1); feed(1, 16'd2);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_async_vld", {31'd0, status_out == VALID}, 32'd0);
    chk("t6_async_data", {16'd0, data_out}, 32'd0);
    chk("t6_async_busy", {31'd0, busy}, 32'd0);
    chk("t6_async_ovf", {31'd0, ovf_err}, 32'd0);
    m_reset();
    @(negedge clk);
    reset = 1'b1;
    cfg(8'd0, 5'd0, 1'b0, 16'd0);
    out_ready = 1'b1;
    feed(1, 16'd9);
    chk("t6_grp0_data", {16'd0, data_out}, 32'd9);
    chk("t6_grp0_vld", {31'd0, status_out == VALID}, 32'd1);

    // Randomized traffic, including mid-pixel config changes
    for (int i = 0; i < 1500; i++) begin
      status_in   = ($urandom_range(0, 9) < 7) ? VALID : INVALID;
      data_in     = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($urandom_range(0, 200) - 100);
      flush       = ($urandom_range(0, 19) == 0);
      out_ready   = ($urandom_range(0, 9) < 6);
      cfg_groups  = 8'($urandom_range(0, 5));
      cfg_shift   = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 4));
      cfg_relu_en = 1'($urandom_range(0, 1));
      bias        = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($urandom_range(0, 64) - 32);
      cycle();
    end
    flush = 1'b0;
    status_in = INVALID;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/psum_accumulator.md
Name: psum_accumulator

Overview:
- Consumes the per-cycle channel-tile sum from the ICP adder tree.
- Accumulates it across `cfg_groups` input-channel groups per output pixel.
- Adds a bias, then applies rounding right-shift, saturation to DATA_WID and optional ReLU.
- Holds the result in an output register with a valid/ready handshake toward the output writer.

Parameters:
- DATA_WID, `CNN_XLEN (16): width of data_in, bias and data_out, two's complement.
- ACC_WID, 2*`CNN_XLEN (32): accumulator width.
- GRP_WID, 8: width of the group counter and of cfg_groups.
- SHF_WID, 5: width of cfg_shift.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- status_in  in  PE_STATE  VALID marks data_in as valid this cycle.
- data_in  in  DATA_WID  signed adder-tree sum.
- flush  in  1  synchronous abort of the pixel in progress.
- cfg_groups  in  GRP_WID  groups per pixel; 0 is treated as 1.
- cfg_shift  in  SHF_WID  arithmetic right-shift amount.
- cfg_relu_en  in  1  ReLU enable.
- bias  in  DATA_WID  signed bias.
- out_ready  in  1  consumer accepts data_out.
- status_out  out  PE_STATE  VALID while the output register holds a result.
- data_out  out  DATA_WID  signed result.
- busy  out  1  accumulation in progress (state ACCUM).
- ovf_err  out  1  sticky: a result was dropped.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, acc=0, grp_cnt=0.
  - status_out=INVALID, data_out=0, busy=0, ovf_err=0.
  - Takes effect immediately, including mid-pixel.
- FSM states:
  - IDLE: grp_cnt=0.
    - A VALID input latches cfg_groups (0→1), cfg_shift, cfg_relu_en and bias into shadow registers.
    - If the latched groups value is 1, the input completes the pixel at once.
    - Otherwise acc=sext(data_in), grp_cnt=1, go to ACCUM.
  - ACCUM: each VALID input does acc += sext(data_in) and grp_cnt++.
    - The input with grp_cnt == groups-1 completes the pixel: go to IDLE, acc=0, grp_cnt=0.
    - INVALID cycles are bubbles: no state change, no timeout.
- Config changes mid-pixel are ignored; the shadow registers are used.
- Completion arithmetic, all in ACC_WID signed:
  - s = acc + sext(data_in) + sext(bias).
  - If shift>0: s = (s + (1<<(shift-1))) >>> shift.
  - Saturate to [-2^(DW-1), 2^(DW-1)-1].
  - Then, if relu_en and the value is negative, result = 0.
  - The accumulator itself wraps at ACC_WID; no internal saturation.
- Latency: the completing input at cycle N gives status_out=VALID and data_out=result at cycle N+1.
- Output handshake:
  - Result is held while status_out=VALID.
  - Popped at a clock edge where status_out=VALID and out_ready=1; status_out then goes INVALID unless a new result loads in the same cycle.
  - data_out keeps its last value when INVALID.
  - Completion while the register is full and not popping: new result dropped, register unchanged, ovf_err set.
  - Completion in the same cycle as a pop: new result loads, no error.
  - Accumulation never stalls on backpressure.
- flush=1:
  - Next edge: state=IDLE, acc=0, grp_cnt=0.
  - Any VALID input in that cycle is discarded.
  - Output register and ovf_err are unaffected.
- ovf_err clears only on reset.
- busy = (state==ACCUM).

Test Plan:
- groups=4, shift=0, bias=0, relu=0, out_ready=1; inputs 10,20,-5,7 back-to-back → single VALID beat data_out=32 one cycle after 7; busy high for 3 cycles.
- groups=3, bias=-50, shift=2; inputs 100, INVALID, INVALID, 200, 300 → data_out=138 (550+2 rounding, >>2); bubbles do not advance grp_cnt.
- groups=2, shift=0, relu=0:
  - 32767+32767 → 32767.
  - -20000+-20000 → -32768.
  - Same inputs with relu=1 → 0.
- Backpressure, groups=1, out_ready=0:
  - Input 5 → data_out=5 held.
  - Input 9 → dropped, data_out stays 5, ovf_err=1.
  - out_ready=1 → pop, status_out INVALID, ovf_err remains 1.
  - Same-cycle pop plus completion of 11 → data_out=11, no new error.
- groups=4; inputs 3,3, then flush with a simultaneous VALID 100, then 1,1,1,1 → data_out=4; the 100 and earlier partial sum are lost.
- Reset and groups=0:
  - Drive reset low mid-pixel between clock edges → outputs INVALID/0 and busy=0 without waiting for a clock edge.
  - After release, cfg_groups=0 and input 9 → data_out=9 next cycle.
